// File: rtl/motor_driver_nch.sv
// N-channel motor drive sequencer: one IDLE/DRIVE_A/DRIVE_B/DEAD FSM per opposing
// channel pair, with level or one-shot pulse drive, dead-time and sticky conflict flags.
module motor_driver_nch #(
  parameter int NCH      = 4,
  parameter int PULSE_W  = 8,
  parameter int DEAD_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic [NCH-1:0]     ch_fire_i,
  input  logic               mode_i,
  input  logic [PULSE_W-1:0] pulse_len_i,
  input  logic               conflict_clr_i,
  output logic [NCH-1:0]     drv_o,
  output logic [NCH/2-1:0]   busy_o,
  output logic [NCH/2-1:0]   conflict_o
);

  localparam int                 NP         = NCH / 2;
  localparam logic [7:0]         DEAD_INIT  = 8'(DEAD_CYC);
  localparam bit                 HAS_DEAD   = (DEAD_CYC != 0);
  localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1'b1);
  localparam logic [PULSE_W-1:0] PULSE_ZERO = {PULSE_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE_A = 2'd1,
    S_DRIVE_B = 2'd2,
    S_DEAD    = 2'd3
  } state_t;

  // A zero pulse length still gives one tick of drive.
  logic [PULSE_W-1:0] w_pulse_init;
  assign w_pulse_init = (pulse_len_i == PULSE_ZERO) ? PULSE_ONE : pulse_len_i;

  genvar gp;
  generate
    for (gp = 0; gp < NP; gp++) begin : g_pair
      state_t             r_state;
      state_t             w_state_nxt;
      logic               r_mode;
      logic               w_mode_nxt;
      logic [PULSE_W-1:0] r_pcnt;
      logic [PULSE_W-1:0] w_pcnt_nxt;
      logic [7:0]         r_dcnt;
      logic [7:0]         w_dcnt_nxt;
      logic               r_drv_a;
      logic               r_drv_b;
      logic               r_busy;
      logic               r_conf;
      logic               w_conf_nxt;
      logic               w_req_a;
      logic               w_req_b;
      logic               w_own;
      logic               w_opp;
      logic               w_exit;

      assign w_req_a = ch_fire_i[2*gp];
      assign w_req_b = ch_fire_i[2*gp+1];
      assign w_own   = (r_state == S_DRIVE_B) ? w_req_b : w_req_a;
      assign w_opp   = (r_state == S_DRIVE_B) ? w_req_a : w_req_b;

      // A new conflict in the same tick as a clear keeps the flag set.
      assign w_conf_nxt = (w_req_a && w_req_b) ? 1'b1 :
                          (conflict_clr_i ? 1'b0 : r_conf);

      // Pair FSM next-state, latched mode and counter updates
      always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pcnt_nxt  = r_pcnt;
        w_dcnt_nxt  = r_dcnt;
        w_exit      = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_req_a && !w_req_b) begin
              w_state_nxt = S_DRIVE_A;
              w_mode_nxt  = mode_i;
              w_pcnt_nxt  = w_pulse_init;
            end else if (w_req_b && !w_req_a) begin
              w_state_nxt = S_DRIVE_B;
              w_mode_nxt  = mode_i;
              w_pcnt_nxt  = w_pulse_init;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          S_DRIVE_A, S_DRIVE_B: begin
            if (r_mode) begin
              w_exit = w_opp || (r_pcnt <= PULSE_ONE);
            end else begin
              w_exit = !w_own || w_opp;
            end
            if (w_exit) begin
              if (HAS_DEAD) begin
                w_state_nxt = S_DEAD;
                w_dcnt_nxt  = DEAD_INIT;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_pcnt_nxt = r_mode ? (r_pcnt - PULSE_ONE) : r_pcnt;
            end
          end
          S_DEAD: begin
            if (r_dcnt <= 8'd1) begin
              w_state_nxt = S_IDLE;
              w_dcnt_nxt  = 8'd0;
            end else begin
              w_dcnt_nxt  = r_dcnt - 8'd1;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end

      // State, counters and registered outputs advance only on ticks
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= S_IDLE;
          r_mode  <= 1'b0;
          r_pcnt  <= PULSE_ZERO;
          r_dcnt  <= 8'd0;
          r_drv_a <= 1'b0;
          r_drv_b <= 1'b0;
          r_busy  <= 1'b0;
          r_conf  <= 1'b0;
        end else if (clk_en) begin
          r_state <= w_state_nxt;
          r_mode  <= w_mode_nxt;
          r_pcnt  <= w_pcnt_nxt;
          r_dcnt  <= w_dcnt_nxt;
          r_drv_a <= (w_state_nxt == S_DRIVE_A);
          r_drv_b <= (w_state_nxt == S_DRIVE_B);
          r_busy  <= (w_state_nxt != S_IDLE);
          r_conf  <= w_conf_nxt;
        end
      end

      assign drv_o[2*gp]   = r_drv_a;
      assign drv_o[2*gp+1] = r_drv_b;
      assign busy_o[gp]    = r_busy;
      assign conflict_o[gp] = r_conf;
    end
  endgenerate

endmodule

// File: tb/tb_motor_driver_nch.sv
// Directed and randomised bench for motor_driver_nch with default parameters
// (NCH=4, PULSE_W=8, DEAD_CYC=2).
module tb_motor_driver_nch;

  localparam int DEAD_CYC = 2;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [3:0] ch_fire_i;
  logic       mode_i;
  logic [7:0] pulse_len_i;
  logic       conflict_clr_i;
  logic [3:0] drv_o;
  logic [1:0] busy_o;
  logic [1:0] conflict_o;

  int n_pass;
  int n_total;

  motor_driver_nch #(.NCH(4), .PULSE_W(8), .DEAD_CYC(DEAD_CYC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .ch_fire_i      (ch_fire_i),
    .mode_i         (mode_i),
    .pulse_len_i    (pulse_len_i),
    .conflict_clr_i (conflict_clr_i),
    .drv_o          (drv_o),
    .busy_o         (busy_o),
    .conflict_o     (conflict_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] d, input logic [1:0] b,
                      input logic [1:0] c);
    chk({tag, ".drv"},  32'(drv_o),      32'(d));
    chk({tag, ".busy"}, 32'(busy_o),     32'(b));
    chk({tag, ".conf"}, 32'(conflict_o), 32'(c));
  endtask

  initial begin
    logic [3:0] prev_drv;
    logic [1:0] prev_pair [2];
    int         zcnt [2];
    logic [1:0] cur;

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    clk_en = 1'b0;
    ch_fire_i = 4'h0;
    mode_i = 1'b0;
    pulse_len_i = 8'd0;
    conflict_clr_i = 1'b0;

    // Reset and hold
    #12;
    outs("in_reset", 4'h0, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    outs("after_reset", 4'h0, 2'b00, 2'b00);
    ch_fire_i = 4'hF;
    for (int i = 0; i < 3; i++) step();
    outs("hold_en0", 4'h0, 2'b00, 2'b00);
    ch_fire_i = 4'h0;
    clk_en = 1'b1;
    step();

    // Level mode: 5 ticks of request give 5 ticks of drive, then 2 dead ticks
    mode_i = 1'b0;
    ch_fire_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      outs($sformatf("level_drv%0d", i), 4'b0001, 2'b01, 2'b00);
    end
    ch_fire_i = 4'b0000;
    step();
    outs("level_dead1", 4'h0, 2'b01, 2'b00);
    step();
    outs("level_dead2", 4'h0, 2'b01, 2'b00);
    step();
    outs("level_idle", 4'h0, 2'b00, 2'b00);

    // Pulse mode, length 3, single-tick request on channel 2
    mode_i = 1'b1;
    pulse_len_i = 8'd3;
    ch_fire_i = 4'b0100;
    step();
    outs("pulse3_t1", 4'b0100, 2'b10, 2'b00);
    ch_fire_i = 4'b0000;
    step();
    outs("pulse3_t2", 4'b0100, 2'b10, 2'b00);
    step();
    outs("pulse3_t3", 4'b0100, 2'b10, 2'b00);
    step();
    outs("pulse3_end", 4'h0, 2'b10, 2'b00);
    step();
    outs("pulse3_dead2", 4'h0, 2'b10, 2'b00);
    step();
    outs("pulse3_idle", 4'h0, 2'b00, 2'b00);

    // Pulse length 0 behaves as 1
    pulse_len_i = 8'd0;
    ch_fire_i = 4'b0100;
    step();
    outs("pulse0_t1", 4'b0100, 2'b10, 2'b00);
    ch_fire_i = 4'b0000;
    step();
    outs("pulse0_end", 4'h0, 2'b10, 2'b00);
    for (int i = 0; i < 3; i++) step();

    // Reversal N -> S in level mode
    mode_i = 1'b0;
    ch_fire_i = 4'b0001;
    step();
    step();
    outs("rev_n_on", 4'b0001, 2'b01, 2'b00);
    ch_fire_i = 4'b0010;
    step();
    outs("rev_n_drop", 4'h0, 2'b01, 2'b00);
    step();
    outs("rev_dead2", 4'h0, 2'b01, 2'b00);
    step();
    outs("rev_idle", 4'h0, 2'b00, 2'b00);
    step();
    outs("rev_s_on", 4'b0010, 2'b01, 2'b00);
    ch_fire_i = 4'b0000;
    for (int i = 0; i < 4; i++) step();

    // Outputs freeze mid-drive while clk_en is low
    ch_fire_i = 4'b0001;
    step();
    clk_en = 1'b0;
    ch_fire_i = 4'b0000;
    step();
    step();
    outs("freeze", 4'b0001, 2'b01, 2'b00);
    clk_en = 1'b1;
    step();
    outs("unfreeze", 4'h0, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++) step();

    // Conflict flags: sticky, clear, set-beats-clear, pair independence
    ch_fire_i = 4'b0011;
    step();
    outs("conf_set", 4'h0, 2'b00, 2'b01);
    ch_fire_i = 4'b0000;
    step();
    outs("conf_sticky", 4'h0, 2'b00, 2'b01);
    conflict_clr_i = 1'b1;
    step();
    outs("conf_clr", 4'h0, 2'b00, 2'b00);
    ch_fire_i = 4'b0011;
    step();
    outs("conf_set_wins", 4'h0, 2'b00, 2'b01);
    conflict_clr_i = 1'b0;
    ch_fire_i = 4'b1011;
    step();
    outs("conf_indep", 4'b1000, 2'b10, 2'b01);
    ch_fire_i = 4'b0000;
    conflict_clr_i = 1'b1;
    step();
    conflict_clr_i = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset during pulse tick 2 of 5
    mode_i = 1'b1;
    pulse_len_i = 8'd5;
    ch_fire_i = 4'b0111;
    step();
    outs("rst_pulse_t1", 4'b0100, 2'b10, 2'b01);
    ch_fire_i = 4'b0000;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    outs("async_rst", 4'h0, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    outs("post_rst", 4'h0, 2'b00, 2'b00);

    // Randomised run: no pair ever both-high, dead gap always respected
    prev_drv = drv_o;
    for (int p = 0; p < 2; p++) begin
      prev_pair[p] = 2'b00;
      zcnt[p] = 255;
    end
    for (int n = 0; n < 10000; n++) begin
      clk_en         = ($urandom_range(0, 3) != 0);
      ch_fire_i      = 4'($urandom_range(0, 15));
      mode_i         = 1'($urandom_range(0, 1));
      pulse_len_i    = 8'($urandom_range(0, 4));
      conflict_clr_i = ($urandom_range(0, 7) == 0);
      step();
      if (!clk_en) begin
        chk("rnd_hold", 32'(drv_o), 32'(prev_drv));
      end else begin
        for (int p = 0; p < 2; p++) begin
          cur = drv_o[2*p +: 2];
          chk($sformatf("rnd_both_high_p%0d", p), 32'(cur == 2'b11), 32'd0);
          if (cur == 2'b00) begin
            zcnt[p]++;
          end else if (prev_pair[p] == 2'b00) begin
            chk($sformatf("rnd_dead_gap_p%0d", p), 32'(zcnt[p] >= DEAD_CYC + 1), 32'd1);
            zcnt[p] = 0;
          end else begin
            chk($sformatf("rnd_direct_swap_p%0d", p), 32'(cur), 32'(prev_pair[p]));
          end
          prev_pair[p] = cur;
        end
      end
      prev_drv = drv_o;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/motor_driver_nch.md
# motor_driver_nch

Parametrised N-channel motor drive sequencer: the next generation of the 4-direction motor decoder. Channels are grouped into opposing pairs (N/S, E/W, …). Per pair it adds level or one-shot pulse drive, a programmable pulse length, mandatory dead-time between opposing drives, and sticky conflict flags. It sits between the channel-fire logic and the motor pins, and advances only on `clk_en` ticks.

## Interface
Parameters:
- `NCH`, default 4: number of channels; must be even. Pair p = channels 2p (A) and 2p+1 (B). Default pairs: 0/1 = N/S, 2/3 = E/W.
- `PULSE_W`, default 8: width of the pulse-length input and of each pulse counter.
- `DEAD_CYC`, default 2: dead-time in ticks, range 0..255. 0 skips the DEAD state.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `clk_en` in 1: tick strobe. All state and counters change only on cycles where `clk_en`=1.
- `ch_fire_i` in NCH: drive requests, bit i = channel i.
- `mode_i` in 1: 0 = level mode, 1 = one-shot pulse mode. Sampled only when a pair is in IDLE.
- `pulse_len_i` in PULSE_W: pulse length in ticks. Sampled on entry to DRIVE; 0 is treated as 1.
- `conflict_clr_i` in 1: clears all conflict flags on a tick.
- `drv_o` out NCH: registered drive outputs, bit i = channel i.
- `busy_o` out NCH/2: bit p = 1 while pair p is not in IDLE.
- `conflict_o` out NCH/2: sticky flag, set when both channels of pair p request in the same tick.

## Operation
- Each pair has an independent FSM with states IDLE, DRIVE_A, DRIVE_B, DEAD.
- Each pair has a pulse counter (PULSE_W bits) and a dead counter (8 bits).
- Outputs per state:
  - IDLE: both drive bits 0.
  - DRIVE_A: bit 2p = 1, bit 2p+1 = 0.
  - DRIVE_B: the mirror of DRIVE_A.
  - DEAD: both drive bits 0.
- In no state are both bits of a pair 1; this holds for every cycle.
- IDLE, on a tick:
  - A only requested: go to DRIVE_A and latch the mode.
  - B only requested: go to DRIVE_B and latch the mode.
  - Both requested: stay in IDLE and set `conflict_o[p]`.
  - Neither requested: stay in IDLE.
- When entering DRIVE, pulse counter = max(pulse_len_i, 1).
- DRIVE_x in level mode: stay while own request = 1 and opposing request = 0. Otherwise exit.
- DRIVE_x in pulse mode:
  - The counter decrements every tick.
  - Exit on the tick where the counter reaches 1, so the drive lasts exactly L ticks.
  - An opposing request aborts early and exits on that tick.
  - The own request level is ignored after entry.
- Exit from DRIVE goes to DEAD with dead counter = DEAD_CYC, or straight to IDLE if DEAD_CYC = 0.
- DEAD: decrement every tick and go to IDLE when the counter reaches 1. Requests are ignored in DEAD.
- Conflict flags:
  - Both requests in DRIVE/DEAD also set `conflict_o[p]`.
  - If a set and `conflict_clr_i` occur in the same tick, set wins.
  - Flags never block drive.
- A request that is held continuously re-triggers after IDLE is reached, one tick later.
- Reset, asynchronous and at any point including mid-pulse: all FSMs go to IDLE, all counters to 0, and `drv_o`, `busy_o`, `conflict_o` all go to 0.

## Timing
- Latency: a request sampled at tick T appears on `drv_o` after the clock edge of tick T. This is a 1-tick registered latency.
- With `clk_en`=0, all outputs hold their previous values.
- Pulse mode with length L: `drv_o` stays high for exactly L ticks, then 0 for DEAD_CYC ticks, then IDLE for at least 1 tick.
- Reversal A→B in level mode: A drops on the tick after B is requested. B asserts no earlier than DEAD_CYC+1 ticks later.
- `busy_o[p]` is high from DRIVE entry through the last DEAD tick.
- Pairs are fully independent; simultaneous events on different pairs do not interact.

## Test plan
- Reset and hold:
  - After `rst_n` is released, all outputs are 0.
  - With `clk_en` held at 0 and `ch_fire_i`=4'hF, outputs stay 0.
- Level mode, DEAD_CYC=2:
  - `ch_fire_i`=4'b0001 for 5 ticks gives `drv_o`[0]=1 for 5 ticks, starting 1 tick later.
  - Then `drv_o`=0 for 2 ticks, with `busy_o`[0]=1 during those ticks.
- Pulse mode, `pulse_len_i`=3, fire pulsed for 1 tick:
  - `drv_o`[2]=1 for exactly 3 ticks.
  - Repeat with `pulse_len_i`=0: 1 tick of drive.
- Reversal: N held, then switch to S in the same tick.
  - N drops on the next tick.
  - S rises exactly DEAD_CYC+1 ticks after the switch.
  - `drv_o`[1:0] never equals 2'b11.
- Conflict:
  - `ch_fire_i`=4'b0011 gives no drive and `conflict_o`[0]=1, which stays set.
  - `conflict_clr_i` with no new conflict clears it.
  - Clear together with a new conflict leaves it at 1.
- Mid-pulse reset: assert `rst_n`=0 during pulse tick 2 of 5; all outputs go to 0 immediately with no clock needed.
- Randomised run: random `clk_en`, `ch_fire_i` and mode over 10k cycles, with assertions that:
  - a pair is never both-high;
  - dead-time is always ≥ DEAD_CYC ticks.
